// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan
//  Description : Time-multiplexed scanner for a 4-digit common-anode display.
//                Presents one packed-BCD digit at a time on `dig` (to the
//                BCD-to-seven-segment decoder) together with the matching
//                active-low anode enable. Digits are latched once per frame
//                (at slot-0 entry) so a frame never mixes old and new values.
//                Masked digits can be blinked for adjust mode.
//
//  Ports       : clk          system clock
//                rst          synchronous reset, active-high
//                digits[15:0] packed BCD {d3,d2,d1,d0}, d0 = rightmost
//                blink_en     enables blinking of masked digits
//                blink_mask   bit i = 1 blinks digit i
//                dig[3:0]     BCD value of the selected digit (registered)
//                an[3:0]      anode enables, active-low (registered)
//                frame_start  one-cycle pulse on slot-0 entry (registered)
//
//  Options     : DISP_LEADING_ZERO_BLANK_EN - when defined, digits 3..1 are
//                blanked while they and every digit to their left are zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scan #(
    parameter int REFRESH_DIV = 100000,  // cycles per digit slot, >= 2
    parameter int BLINK_DIV   = 50000000 // cycles per blink half-period, >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  dig,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int c_REF_W = $clog2(REFRESH_DIV);
    localparam int c_BLK_W = $clog2(BLINK_DIV);

    logic [c_REF_W-1:0] r_ref_cnt;
    logic [1:0]         r_slot;
    logic [15:0]        r_shadow;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [3:0]         r_dig;
    logic [3:0]         r_an;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_blink_tc;
    logic [1:0]         w_next;
    logic [3:0]         w_lz_blank;
    logic               w_blank;

    assign w_tick     = (r_ref_cnt == c_REF_W'(REFRESH_DIV - 1));
    assign w_blink_tc = (r_blink_cnt == c_BLK_W'(BLINK_DIV - 1));
    assign w_next     = r_slot + 2'd1;

`ifdef DISP_LEADING_ZERO_BLANK_EN
    // Digit i is a leading zero when it and every digit to its left are zero.
    // Only slots 1..3 are ever considered; the rightmost digit always shows.
    assign w_lz_blank[0] = 1'b0;
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
        assign w_lz_blank[gi] = (r_shadow[15:4*gi] == '0);
    end
`else
    assign w_lz_blank = 4'b0000;
`endif

    // Blanking uses the live mask and the current phase at the tick; the
    // digit value is still driven so the decoder path is unchanged.
    assign w_blank = (blink_en & blink_mask[w_next] & r_blink_phase)
                   | w_lz_blank[w_next];

    // Slot timing and digit selection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt     <= '0;
            r_slot        <= 2'd3;   // first tick advances to slot 0
            r_shadow      <= 16'h0000;
            r_dig         <= 4'h0;
            r_an          <= 4'b1111;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_ref_cnt <= '0;
                r_slot    <= w_next;
                if (w_next == 2'd0) begin
                    // New frame: capture all digits at once, and show d0
                    // straight from the input since shadow updates this edge.
                    r_shadow      <= digits;
                    r_dig         <= digits[3:0];
                    r_frame_start <= 1'b1;
                end else begin
                    r_dig <= r_shadow[{w_next, 2'b00} +: 4];
                end
                r_an <= w_blank ? 4'b1111 : ~(4'b0001 << w_next);
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
        end
    end

    // Blink timebase; held at zero while disabled so enabling always begins
    // with a visible half-period.
    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_tc) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign dig         = r_dig;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_scan
//  Description : Self-checking bench for disp_scan (REFRESH_DIV=4,
//                BLINK_DIV=16). A time-based reference model derives slot,
//                blink phase and frame contents from elapsed-cycle arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic        blink_en = 1'b0;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  dig;
    logic [3:0]  an;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_n;      // edges since reset release
    int          m_b;      // consecutive edges with blink_en high
    int          m_slot;
    logic [15:0] m_sh;
    logic [3:0]  e_dig;
    logic [3:0]  e_an;
    logic        e_fs;
    bit          m_entry;  // last edge was a slot entry

    disp_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .blink_en    (blink_en),
        .blink_mask  (blink_mask),
        .dig         (dig),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Advance the model by one edge using the inputs the DUT will sample,
    // then let the edge happen and settle.
    task automatic step();
        int  nxt;
        bit  phase;
        bit  blank;
        m_entry = 1'b0;
        if (rst) begin
            m_n = 0; m_b = 0; m_sh = 16'h0000; m_slot = 3;
            e_an = 4'hF; e_dig = 4'h0; e_fs = 1'b0;
        end else begin
            phase = ((m_b / BLINK_DIV) % 2) == 1;
            m_n++;
            e_fs = 1'b0;
            if (m_n % REFRESH_DIV == 0) begin
                m_entry = 1'b1;
                nxt = ((m_n / REFRESH_DIV) + 3) % 4;
                m_slot = nxt;
                if (nxt == 0) begin
                    m_sh = digits;
                    e_fs = 1'b1;
                end
                e_dig = 4'((m_sh >> (4 * nxt)) & 16'hF);
                blank = blink_en && blink_mask[nxt] && phase;
`ifdef DISP_LEADING_ZERO_BLANK_EN
                if (nxt != 0 && (m_sh >> (4 * nxt)) == 16'h0) blank = 1'b1;
`endif
                e_an = blank ? 4'hF : ~(4'b0001 << nxt);
            end
            m_b = blink_en ? m_b + 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; digits = 16'h1234; blink_en = 1'b0; blink_mask = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (an !== 4'hF || dig !== 4'h0 || frame_start !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold dig/an/fs=%h/%b/%b required 0/1111/0", dig, an, frame_start);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (an !== 4'hF || dig !== 4'h0 || frame_start !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d dig/an/fs=%h/%b/%b required 0/1111/0", i, dig, an, frame_start);
            end
        end
        step();
        checks++;
        if (an !== 4'b1110 || dig !== 4'h4 || frame_start !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_tick dig/an/fs=%h/%b/%b required 4/1110/1", dig, an, frame_start);
        end
        step();
        checks++;
        if (an !== 4'b1110 || dig !== 4'h4 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_fs_width dig/an/fs=%h/%b/%b required 4/1110/0", dig, an, frame_start);
        end
    endtask

    task automatic test_scan();
        int fs_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (frame_start === 1'b1) fs_cnt++;
            checks++;
            if ({dig, an, frame_start} !== {e_dig, e_an, e_fs}) begin
                failures++;
                $display("FAIL scan cyc=%0d dig/an/fs=%h/%b/%b expected %h/%b/%b", i, dig, an, frame_start, e_dig, e_an, e_fs);
            end
        end
        checks++;
        if (fs_cnt != 2) begin
            failures++;
            $display("FAIL scan_fs_count got=%0d required=2", fs_cnt);
        end
    endtask

    task automatic test_coherence();
        logic [3:0] exp_seq [6] = '{4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
        int idx = 0;
        int guard = 0;
        while (m_slot != 1 && guard < 40) begin step(); guard++; end
        if (m_slot != 1) begin
            checks++; failures++;
            $display("FAIL coherence_wait slot=%0d required=1", m_slot);
        end
        digits = 16'h5678;
        guard = 0;
        while (idx < 6 && guard < 40) begin
            step();
            guard++;
            checks++;
            if ({dig, an, frame_start} !== {e_dig, e_an, e_fs}) begin
                failures++;
                $display("FAIL coherence cyc=%0d dig/an/fs=%h/%b/%b expected %h/%b/%b", guard, dig, an, frame_start, e_dig, e_an, e_fs);
            end
            if (m_entry) begin
                checks++;
                if (dig !== exp_seq[idx]) begin
                    failures++;
                    $display("FAIL coherence_seq entry=%0d dig=%h required=%h", idx, dig, exp_seq[idx]);
                end
                idx++;
            end
        end
        if (idx < 6) begin
            checks++; failures++;
            $display("FAIL coherence_timeout entries=%0d required=6", idx);
        end
    endtask

    task automatic test_blink();
        int lit = 0;
        int dark = 0;
        int guard = 0;
        digits = 16'h1234; blink_mask = 4'b0010; blink_en = 1'b1;
        for (int i = 0; i < 96; i++) begin
            step();
            checks++;
            if ({dig, an, frame_start} !== {e_dig, e_an, e_fs}) begin
                failures++;
                $display("FAIL blink cyc=%0d dig/an/fs=%h/%b/%b expected %h/%b/%b", i, dig, an, frame_start, e_dig, e_an, e_fs);
            end
            if (m_entry && m_slot == 1) begin
                if (an === 4'b1101) lit++;
                if (an === 4'b1111) dark++;
            end
        end
        checks++;
        if (lit == 0 || dark == 0) begin
            failures++;
            $display("FAIL blink_alternate lit=%0d dark=%0d required both nonzero", lit, dark);
        end
        blink_en = 1'b0;
        do begin step(); guard++; end while (!(m_entry && m_slot == 1) && guard < 40);
        checks++;
        if (an !== 4'b1101 || dig !== 4'h3) begin
            failures++;
            $display("FAIL blink_off dig/an=%h/%b required 3/1101", dig, an);
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (m_slot != 2 && guard < 40) begin step(); guard++; end
        if (m_slot != 2) begin
            checks++; failures++;
            $display("FAIL midreset_wait slot=%0d required=2", m_slot);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (an !== 4'hF || dig !== 4'h0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state dig/an/fs=%h/%b/%b required 0/1111/0", dig, an, frame_start);
        end
        rst = 1'b0; digits = 16'h9abc;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (an !== 4'hF || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle an/fs=%b/%b required 1111/0", an, frame_start);
        end
        step();
        checks++;
        if (an !== 4'b1110 || dig !== 4'hc || frame_start !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reentry dig/an/fs=%h/%b/%b required c/1110/1", dig, an, frame_start);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if ({dig, an, frame_start} !== {e_dig, e_an, e_fs}) begin
                failures++;
                $display("FAIL midreset cyc=%0d dig/an/fs=%h/%b/%b expected %h/%b/%b", i, dig, an, frame_start, e_dig, e_an, e_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19, 0) == 0) digits = 16'($urandom());
            if ($urandom_range(39, 0) == 0) blink_en = ~blink_en;
            if ($urandom_range(29, 0) == 0) blink_mask = 4'($urandom());
            step();
            checks++;
            if ({dig, an, frame_start} !== {e_dig, e_an, e_fs}) begin
                failures++;
                $display("FAIL random cyc=%0d dig/an/fs=%h/%b/%b expected %h/%b/%b", i, dig, an, frame_start, e_dig, e_an, e_fs);
            end
        end
        blink_en = 1'b0; blink_mask = 4'b0000;
    endtask

    task automatic test_lz();
        logic [3:0] req_an [4];
        int guard = 0;
        int seen = 0;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        req_an = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
        req_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
        digits = 16'h0040;
        do begin step(); guard++; end while (!e_fs && guard < 40);
        while (seen < 4 && guard < 80) begin
            if (m_entry) begin
                checks++;
                if (an !== req_an[m_slot] || dig !== ((m_slot == 1) ? 4'h4 : 4'h0)) begin
                    failures++;
                    $display("FAIL lz_0040 slot=%0d dig/an=%h/%b required an=%b", m_slot, dig, an, req_an[m_slot]);
                end
                seen++;
            end
            step();
            guard++;
        end
        if (seen < 4) begin
            checks++; failures++;
            $display("FAIL lz_timeout entries=%0d required=4", seen);
        end
        digits = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({dig, an, frame_start} !== {e_dig, e_an, e_fs}) begin
                failures++;
                $display("FAIL lz_zero cyc=%0d dig/an/fs=%h/%b/%b expected %h/%b/%b", i, dig, an, frame_start, e_dig, e_an, e_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_coherence();
        test_blink();
        test_mid_reset();
        test_random();
        test_lz();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_scan.md
Name: disp_scan

Overview:
- Time-multiplexed scanner for the 4-digit common-anode display.
- Sits directly upstream of the BCD-to-seven-segment decoder.
- Takes four packed BCD digits from the counter logic and presents one digit at a time on `dig` for the decoder, with the matching active-low anode enable.
- Adds frame-coherent digit latching and per-digit blinking for adjust mode.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit slot is held (1 kHz/slot at 100 MHz); must be >= 2
- BLINK_DIV, 50000000, clock cycles per blink half-period (0.5 s at 100 MHz); must be >= 2

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- digits  input  16  packed BCD {d3,d2,d1,d0}; d0 = rightmost digit
- blink_en  input  1  enables blinking of masked digits
- blink_mask  input  4  bit i = 1 blinks digit i
- dig  output  4  BCD value of the currently selected digit, to the decoder
- an  output  4  anode enables, active-low, bit i = digit i
- frame_start  output  1  one-cycle pulse when slot 0 is entered

Behaviour:
- Reset values, applied on the rising clk edge with rst = 1:
  - refresh counter = 0, slot = 3, shadow digits = 16'h0000
  - blink counter = 0, blink_phase = 0
  - an = 4'b1111, dig = 4'h0, frame_start = 0
- All outputs are registered. A reset asserted mid-operation returns every register to its reset value on the next edge, and scanning restarts from the beginning.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - `tick` = 1 in the cycle where the count equals REFRESH_DIV-1.
  - The first tick occurs on the REFRESH_DIV-th edge after rst deasserts.
- On each tick, with next = slot+1 mod 4:
  - slot <= next.
  - If next == 0: shadow <= digits, dig <= digits[3:0], frame_start <= 1.
  - Otherwise: dig <= shadow[4*next+3:4*next], frame_start <= 0.
  - an <= ~(4'b0001 << next), or 4'b1111 if digit `next` is blanked.
- When there is no tick: dig and an hold their values, and frame_start <= 0.
- Scan order: d0, d1, d2, d3, then repeat. Each slot is held exactly REFRESH_DIV cycles; a frame is 4*REFRESH_DIV cycles.
- Frame coherence: changes on `digits` within a frame are not visible until the next slot-0 entry.
- Blink timing:
  - While blink_en = 1, the blink counter counts 0..BLINK_DIV-1 and blink_phase toggles on its terminal count.
  - While blink_en = 0, the counter and blink_phase are held at 0, so enabling blinking always starts with a visible half-period.
- Blanking:
  - Digit i is blanked when blink_en & blink_mask[i] & blink_phase.
  - The condition is evaluated using live blink_mask and phase at the tick.
  - A blanked digit still drives its value on `dig`; only `an` goes to 4'b1111.
- Values > 9 pass through unmodified; the decoder's default handles them.
- Counter widths are $clog2 of the respective divider. There is no overflow beyond the terminal count.

Optional Feature:
- Macro: DISP_LEADING_ZERO_BLANK_EN.
- When defined: digit i (i = 3, 2, 1) is additionally blanked (an = 4'b1111 in its slot) if the shadow digits i..3 are all 4'h0. Digit 0 is never blanked by this rule. Evaluation uses shadow for slots 1..3; slot 0 needs no evaluation.
- When undefined: no leading-zero logic is generated and all four digits are shown.

Test Plan:
(All scenarios use REFRESH_DIV = 4 and BLINK_DIV = 16.)
- Reset:
  - Stimulus: rst = 1 for 2 cycles, digits = 16'h1234, then release.
  - Required: an = 1111, dig = 0 for 4 cycles. Then an = 1110, dig = 4, and frame_start = 1 for exactly one cycle.
- Scan:
  - Stimulus: digits = 16'h1234 held.
  - Required: dig/an sequence 4/1110, 3/1101, 2/1011, 1/0111, each held 4 cycles, repeating every 16 cycles. frame_start pulses every 16 cycles.
- Coherence:
  - Stimulus: change digits to 16'h5678 during slot 1.
  - Required: the current frame still shows 2 then 1; the next frame shows 8, 7, 6, 5.
- Blink:
  - Stimulus: blink_en = 1, blink_mask = 4'b0010.
  - Required: slot 1 shows an = 1101 for the first 16 cycles and 1111 for the next 16, alternating; the other slots are unaffected. Dropping blink_en makes slot 1 visible at its next slot entry.
- Reset mid-frame:
  - Stimulus: assert rst during slot 2 for 1 cycle.
  - Required: next edge gives an = 1111, dig = 0. Slot 0 is re-entered 4 cycles after release, with shadow reloaded.
- DISP_LEADING_ZERO_BLANK_EN defined:
  - Stimulus: digits = 16'h0040.
  - Required: slots 3 and 2 give an = 1111; slot 1 gives 1101 with dig = 4; slot 0 gives 1110 with dig = 0. With 16'h0000, only digit 0 is lit.
